// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the segmented pipelined adder.
//   ADDER_WIDTH / ADDER_SEG_W : default operand width and per-stage segment width.
//   num_seg()                 : number of pipeline stages for a width/segment pair.
//   seg_cfg_ok()              : legality check used at elaboration time.
package adder_pkg;

  localparam int ADDER_WIDTH = 32;
  localparam int ADDER_SEG_W = 16;

  function automatic int num_seg(input int width, input int seg_w);
    return (seg_w > 0) ? (width / seg_w) : 0;
  endfunction

  function automatic bit seg_cfg_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline stage of the segmented adder: a SEG_W-bit add with carry
// in/out followed by a valid/ready register slice.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : upstream handshake (in_ready is combinational)
//   a_seg, b_seg, c_in   : the segment this stage resolves and its carry-in
//   pass_in / pass_out   : payload carried alongside (unprocessed operand
//                          segments, already-computed lower sum segments)
//   out_valid / out_ready: downstream handshake
//   sum, c_out           : registered segment result and carry-out
module adder_seg_stage #(
  parameter int SEG_W  = 16,
  parameter int PASS_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEG_W-1:0]  a_seg,
  input  logic [SEG_W-1:0]  b_seg,
  input  logic              c_in,
  input  logic [PASS_W-1:0] pass_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEG_W-1:0]  sum,
  output logic              c_out,
  output logic [PASS_W-1:0] pass_out
);

  logic              valid_q, valid_d;
  logic [SEG_W-1:0]  sum_q, sum_d;
  logic              c_q, c_d;
  logic [PASS_W-1:0] pass_q, pass_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    sum_d    = sum_q;
    c_d      = c_q;
    pass_d   = pass_q;
    if (in_ready) begin
      valid_d = in_valid;
      // Data only moves with a real beat; a bubble leaves the slice untouched.
      if (in_valid) begin
        {c_d, sum_d} = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_in};
        pass_d       = pass_in;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of evaluation order.
  // NOTE: data registers are reset as well as the valid bit, so the result
  // outputs read 0 while the pipeline is empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      pass_q  <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      pass_q  <= pass_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign c_out     = c_q;
  assign pass_out  = pass_q;

endmodule

// File: rtl/pipelined_seg_adder.sv
// Pipelined WIDTH-bit adder/subtractor resolved SEG_W bits per stage.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready is a combinational
//                         bubble-collapsing ready chain)
//   A, B, C_in, sub     : sub=0 -> A+B+C_in, sub=1 -> A-B (C_in ignored)
//   out_valid/out_ready : result handshake
//   S, C_out, OVF       : result, carry out of the MSB (1 = no borrow when
//                         subtracting), two's-complement signed overflow
// Latency NUM_SEG cycles, one beat per cycle.
module pipelined_seg_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int SEG_W = ADDER_SEG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             OVF
);

  localparam int NUM_SEG = num_seg(WIDTH, SEG_W);

  if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_cfg_check
    $error("pipelined_seg_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  // Subtraction is folded into the operands once, at capture.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  always_comb begin
    b_eff   = sub ? ~B : B;
    cin_eff = sub ? 1'b1 : C_in;
  end

  // Stage k payload layout (MSB first):
  //   middle stages: {A' upper segs, B' upper segs, sum segs below k}
  //   last stage   : {A' MSB, B' MSB, sum segs below k}
  // The last stage keeps only the two operand MSBs the overflow flag needs.
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    localparam int REM_W  = (NUM_SEG - k) * SEG_W;
    localparam bit LAST   = (k == NUM_SEG - 1);
    localparam int UP_W   = LAST ? 2 : 2 * (REM_W - SEG_W);
    localparam int LO_W   = k * SEG_W;
    localparam int PASS_W = UP_W + LO_W;

    logic [REM_W-1:0]  a_rem;
    logic [REM_W-1:0]  b_rem;
    logic              c_rem;
    logic              v_in;
    logic              rdy_in;
    logic              rdy_out;
    logic              v_out;
    logic              c_out;
    logic [UP_W-1:0]   up;
    logic [PASS_W-1:0] pass_in;
    logic [PASS_W-1:0] pass_out;
    logic [SEG_W-1:0]  sum;

    if (LAST) begin : g_up_last
      assign up      = {a_rem[REM_W-1], b_rem[REM_W-1]};
      assign rdy_out = out_ready;
    end else begin : g_up_mid
      assign up      = {a_rem[REM_W-1:SEG_W], b_rem[REM_W-1:SEG_W]};
      assign rdy_out = g_stage[k+1].rdy_in;
    end

    if (k == 0) begin : g_first
      assign a_rem    = A;
      assign b_rem    = b_eff;
      assign c_rem    = cin_eff;
      assign v_in     = in_valid;
      assign pass_in  = up;
      assign in_ready = rdy_in;
    end else begin : g_next
      localparam int PREV_LO_W = (k - 1) * SEG_W;
      assign a_rem = g_stage[k-1].pass_out[PREV_LO_W + REM_W +: REM_W];
      assign b_rem = g_stage[k-1].pass_out[PREV_LO_W +: REM_W];
      assign c_rem = g_stage[k-1].c_out;
      assign v_in  = g_stage[k-1].v_out;
      if (k == 1) begin : g_lo_one
        assign pass_in = {up, g_stage[k-1].sum};
      end else begin : g_lo_many
        assign pass_in = {up, g_stage[k-1].sum, g_stage[k-1].pass_out[PREV_LO_W-1:0]};
      end
    end

    adder_seg_stage #(
      .SEG_W  (SEG_W),
      .PASS_W (PASS_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_in),
      .in_ready  (rdy_in),
      .a_seg     (a_rem[SEG_W-1:0]),
      .b_seg     (b_rem[SEG_W-1:0]),
      .c_in      (c_rem),
      .pass_in   (pass_in),
      .out_valid (v_out),
      .out_ready (rdy_out),
      .sum       (sum),
      .c_out     (c_out),
      .pass_out  (pass_out)
    );

    if (LAST) begin : g_out
      logic a_msb;
      logic b_msb;
      assign a_msb     = pass_out[LO_W+1];
      assign b_msb     = pass_out[LO_W];
      assign out_valid = v_out;
      assign C_out     = c_out;
      if (k == 0) begin : g_s_single
        assign S = sum;
      end else begin : g_s_multi
        assign S = {sum, pass_out[LO_W-1:0]};
      end
      // Same-sign operands producing a result of the other sign.
      assign OVF = (a_msb == b_msb) && (S[WIDTH-1] != a_msb);
    end
  end

endmodule
